// File: rtl/wb_lcd_ctrl_pkg.sv
// Shared definitions for the Wishbone HD44780 controller: register map, STATUS bits, FSM states.
package lcd_pkg;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int unsigned ST_BUSY   = 0;
  localparam int unsigned ST_FULL   = 1;
  localparam int unsigned ST_EMPTY  = 2;
  localparam int unsigned ST_OVF    = 3;
  localparam int unsigned ST_BFTO   = 4;
  localparam int unsigned ST_BF_LSB = 8;

  localparam int unsigned ENTRY_W = 9;
  localparam int unsigned RS_BIT  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StBfAs,
    StBfE,
    StBfRec,
    StWrAs,
    StWrE,
    StWrRec
  } lcd_state_e;

endpackage

// File: rtl/wb_lcd_ctrl_if.sv
// Wishbone slave bus bundle for wb_lcd_ctrl; signal names follow the slave's point of view.
interface wb_lcd_ctrl_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_lcd_ctrl_fifo.sv
// Synchronous FIFO of {rs, byte} entries; simultaneous push and pop leave the count unchanged.
module lcd_fifo
  import lcd_pkg::*;
#(
  parameter int unsigned AW = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [AW:0]        count_o
);

  localparam int unsigned Depth = 1 << AW;

  logic [ENTRY_W-1:0] mem_q [Depth];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [AW:0]        cnt_q, cnt_d;
  logic               do_push, do_pop;

  assign full_o  = (cnt_q == Depth[AW:0]);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_lcd_ctrl.sv
// Wishbone-fed HD44780 8-bit bus driver: polls the busy flag before every queued write.
// Optional busy-poll timeout is enabled by defining LCD_BF_TIMEOUT_EN.
module wb_lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned FIFO_AW    = 2,
  parameter int unsigned T_AS       = 6,
  parameter int unsigned T_PW       = 45,
  parameter int unsigned T_REC      = 60,
  parameter int unsigned BF_TIMEOUT = 1000
) (
  input  logic                clk,
  input  logic                reset,
  wb_lcd_ctrl_if.slave        wb,
  output logic                intr,
  output logic                lcd_e,
  output logic                lcd_rs,
  output logic                lcd_rw,
  output logic [7:0]          lcd_data_o,
  input  logic [7:0]          lcd_data_i,
  output logic                lcd_data_oe
);

  localparam int unsigned CntW = 16;

  lcd_state_e         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               ack_q, intr_q, ovf_q, bft_q;
  logic [31:0]        dat_q, dat_d, status_w;
  logic [7:0]         bf_q;
  logic               req, wr, rd, push, pop, bf_sample, bft_set;
  logic [1:0]         addr;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full, fifo_empty;
  logic [FIFO_AW:0]   unused_count;
  logic               unused_bits;

  assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_dat_i[31:8]};

  // ack_q in the request term keeps a held strobe from getting back-to-back acks.
  assign req  = wb.wb_stb_i && wb.wb_cyc_i && !ack_q;
  assign wr   = req && wb.wb_we_i;
  assign rd   = req && !wb.wb_we_i;
  assign addr = wb.wb_adr_i[3:2];
  assign push = wr && (addr == REG_CMD || addr == REG_DATA);

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign intr        = intr_q;

  lcd_fifo #(
    .AW(FIFO_AW)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (reset),
    .push_i (push),
    .wdata_i({addr == REG_DATA, wb.wb_dat_i[7:0]}),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(unused_count)
  );

  always_comb begin
    status_w                   = '0;
    status_w[ST_BUSY]          = (state_q != StIdle);
    status_w[ST_FULL]          = fifo_full;
    status_w[ST_EMPTY]         = fifo_empty;
    status_w[ST_OVF]           = ovf_q;
    status_w[ST_BFTO]          = bft_q;
    status_w[ST_BF_LSB +: 8]   = bf_q;
    dat_d = (rd && addr == REG_STATUS) ? status_w : '0;
  end

`ifdef LCD_BF_TIMEOUT_EN
  logic [CntW-1:0] polls_q, polls_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) polls_q <= '0;
    else        polls_q <= polls_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - CntW'(1) : '0;
    pop       = 1'b0;
    bf_sample = 1'b0;
    bft_set   = 1'b0;
`ifdef LCD_BF_TIMEOUT_EN
    polls_d   = polls_q;
`endif
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StBfAs;
          cnt_d   = CntW'(T_AS - 1);
`ifdef LCD_BF_TIMEOUT_EN
          polls_d = '0;
`endif
        end
      end
      StBfAs: if (cnt_q == '0) begin
        state_d = StBfE;
        cnt_d   = CntW'(T_PW - 1);
      end
      StBfE: if (cnt_q == '0) begin
        bf_sample = 1'b1;
        state_d   = StBfRec;
        cnt_d     = CntW'(T_REC - 1);
      end
      StBfRec: if (cnt_q == '0) begin
        cnt_d   = CntW'(T_AS - 1);
        state_d = StWrAs;
        if (bf_q[7]) begin
`ifdef LCD_BF_TIMEOUT_EN
          if (polls_q >= CntW'(BF_TIMEOUT - 1)) begin
            bft_set = 1'b1;
          end else begin
            polls_d = polls_q + CntW'(1);
            state_d = StBfAs;
          end
`else
          state_d = StBfAs;
`endif
        end
      end
      StWrAs: if (cnt_q == '0) begin
        state_d = StWrE;
        cnt_d   = CntW'(T_PW - 1);
      end
      StWrE: if (cnt_q == '0) begin
        state_d = StWrRec;
        cnt_d   = CntW'(T_REC - 1);
      end
      StWrRec: if (cnt_q == '0) begin
        pop     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus pins decode straight from the state so an async reset drops E and OE at once.
  always_comb begin
    lcd_e       = 1'b0;
    lcd_rs      = 1'b0;
    lcd_rw      = 1'b0;
    lcd_data_o  = '0;
    lcd_data_oe = 1'b0;
    case (state_q)
      StBfAs, StBfRec: lcd_rw = 1'b1;
      StBfE: begin
        lcd_rw = 1'b1;
        lcd_e  = 1'b1;
      end
      StWrAs, StWrE, StWrRec: begin
        lcd_rs      = head[RS_BIT];
        lcd_data_o  = head[7:0];
        lcd_data_oe = 1'b1;
        lcd_e       = (state_q == StWrE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      intr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bft_q   <= 1'b0;
      bf_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= req;
      dat_q   <= dat_d;
      intr_q  <= (state_q == StIdle) && fifo_empty;
      if (bf_sample) bf_q <= lcd_data_i;
      if (wr && addr == REG_STATUS) begin
        ovf_q <= (ovf_q && !wb.wb_dat_i[ST_OVF]) || (push && fifo_full);
        bft_q <= (bft_q && !wb.wb_dat_i[ST_BFTO]) || bft_set;
      end else begin
        ovf_q <= ovf_q || (push && fifo_full);
        bft_q <= bft_q || bft_set;
      end
    end
  end

endmodule

// File: doc/wb_lcd_ctrl.md
Name: wb_lcd_ctrl

Overview:
- Wishbone slave that accepts HD44780 command and data bytes from the LM32 data bus into a small FIFO.
- Drives the 8-bit LCD bus: E, RS, RW and data, with programmable setup, pulse and recovery timing.
- Before each write it reads the LCD busy flag (RW=1 read cycles), so it is the read side of the currently write-only LCD interface.
- Occupies one conbus slave slot (32-bit address decode by conbus); `intr` goes to the interrupt vector.

Parameters:
- FIFO_AW, 2, log2 of FIFO depth (depth 4 entries × 9 bits {rs, byte}).
- T_AS, 6, clk cycles RS/RW/data setup before E rises (60 ns at 100 MHz).
- T_PW, 45, clk cycles E high.
- T_REC, 60, clk cycles E low after fall (hold plus recovery) before the next phase.
- BF_TIMEOUT, 1000, max busy-flag polls per entry (only used with LCD_BF_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wb_adr_i  in  32  Wishbone address; only [3:2] decoded.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_sel_i  in  4  byte selects; ignored, full-word access.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_we_i  in  1  write enable.
- wb_ack_o  out  1  acknowledge.
- intr  out  1  level: FIFO empty and engine idle.
- lcd_e  out  1  LCD enable.
- lcd_rs  out  1  register select (0 = command, 1 = data).
- lcd_rw  out  1  1 = read, 0 = write.
- lcd_data_o  out  8  LCD data out.
- lcd_data_i  in  8  LCD data in; pad tristate is in the top level.
- lcd_data_oe  out  1  1 = drive lcd_data_o onto the pad.

Behaviour:
- Reset (async, reset=0): every output is 0, FIFO emptied, sticky flags cleared, FSM=IDLE.
  - Asserting reset mid-transfer forces lcd_e=0 immediately and abandons the entry.
- Wishbone:
  - wb_ack_o pulses for exactly 1 cycle, registered, the cycle after stb&cyc with ack=0. No back-to-back ack.
  - wb_dat_o is valid in the ack cycle; 0 otherwise.
- Register map, indexed by wb_adr_i[3:2]:
  - 0 CMD, W: push {0, dat_i[7:0]}.
  - 1 DATA, W: push {1, dat_i[7:0]}.
  - 2 STATUS, R: [0] engine busy (FSM≠IDLE), [1] fifo_full, [2] fifo_empty, [3] ovf sticky, [4] bf_timeout sticky, [15:8] last busy-flag/AC byte sampled, other bits 0.
  - 2 STATUS, W: writing 1 to bit [3] or [4] clears that flag.
  - 3: reads 0, writes ignored.
  - Reads of 0 and 1 return 0.
- FIFO full plus push: data dropped, ovf set, ack still given.
- Push and pop in the same cycle: both honoured, count unchanged.
- FSM (each timed state loads a down-counter; leaves when it reaches 0):
  - IDLE: when FIFO is non-empty → BF_AS.
  - BF_AS: rs=0, rw=1, oe=0, for T_AS cycles → BF_E.
  - BF_E: e=1 for T_PW cycles; lcd_data_i is sampled into the status byte on the last E-high cycle → BF_REC.
  - BF_REC: e=0 for T_REC cycles. If sampled bit7=1 → BF_AS again; else → WR_AS.
  - WR_AS: rs=head.rs, rw=0, oe=1, data=head.byte, for T_AS cycles → WR_E.
  - WR_E: e=1 for T_PW cycles → WR_REC.
  - WR_REC: e=0, data/rs held, for T_REC cycles. Pop FIFO on the last cycle → IDLE.
  - Minimum per entry = 2·(T_AS+T_PW+T_REC) cycles.
- oe=0 in every state except WR_*. rw returns to 0 in IDLE. E never toggles in IDLE.
- intr: registered; 1 when FSM=IDLE and FIFO empty. Rises 1 cycle after reset release.

Optional Feature:
- LCD_BF_TIMEOUT_EN defined: a poll counter is cleared on entry to BF_AS from IDLE. After BF_TIMEOUT consecutive polls with bit7=1 → WR_AS anyway and set STATUS[4].
- Not defined: polls indefinitely; STATUS[4] reads 0.

Decomposition:
- Package lcd_pkg holds:
  - register offsets (REG_CMD=0, REG_DATA=1, REG_STATUS=2);
  - STATUS bit indices;
  - FSM state encoding (7 states, 3 bits);
  - FIFO entry width 9 and the rs bit position.
- One sub-module, lcd_fifo: synchronous FIFO, depth 2**FIFO_AW, 9-bit entries, async active-low reset, full/empty/count outputs, simultaneous push+pop.

Test Plan:
- Reset release, no traffic → all LCD outputs 0, intr=1 after 1 cycle, STATUS read = 0x00000004.
- Write CMD 0x38, LCD model returns bit7=0:
  - one BF read cycle with rw=1, oe=0, e high for 45 cycles;
  - then a write with rs=0, data=0x38, oe=1, e high 45 cycles;
  - intr returns to 1 after 222 cycles.
- Write DATA 0x41 with the model busy for 3 polls (0x80 ×3, then 0x05):
  - 4 BF cycles;
  - STATUS[15:8]=0x05;
  - rs=1 write of 0x41.
- 5 rapid pushes with the engine stalled (bit7=1) → STATUS[1]=1, [3]=1. Write STATUS 0x8 → [3]=0. Release busy → exactly 4 bytes written, in order.
- With LCD_BF_TIMEOUT_EN, BF_TIMEOUT=3, bit7 stuck at 1 → 3 polls, then the write proceeds, STATUS[4]=1. Without the macro, polling continues past 3 and no write occurs.
- Assert reset during WR_E → lcd_e, lcd_data_oe and lcd_data_o are 0 in the same cycle; after release the FIFO is empty.
